// File: rtl/tdm_demux_1x4.sv
// Receive side of the 4:1 TDM link: rebuilds four parallel channel words
// from a rotating single-channel stream, aligned on frame_sync (channel 0).
//
// state  | meaning
// -------+----------------------------------------------------------
// HUNT   | waiting for a frame_sync word; all other words discarded
// LOCKED | aligned; slot tracks the next expected channel index
module tdm_demux_1x4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] ch0_out,
  output logic [WIDTH-1:0] ch1_out,
  output logic [WIDTH-1:0] ch2_out,
  output logic [WIDTH-1:0] ch3_out,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err,
  output logic [1:0]       slot
);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       slot_nxt;
  logic [WIDTH-1:0] sh0, sh1, sh2;
  logic [WIDTH-1:0] sh0_nxt, sh1_nxt, sh2_nxt;
  logic [WIDTH-1:0] ch0_nxt, ch1_nxt, ch2_nxt, ch3_nxt;
  logic             frame_valid_nxt, sync_err_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HUNT;
      slot        <= 2'd0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      ch0_out     <= '0;
      ch1_out     <= '0;
      ch2_out     <= '0;
      ch3_out     <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      slot        <= slot_nxt;
      sh0         <= sh0_nxt;
      sh1         <= sh1_nxt;
      sh2         <= sh2_nxt;
      ch0_out     <= ch0_nxt;
      ch1_out     <= ch1_nxt;
      ch2_out     <= ch2_nxt;
      ch3_out     <= ch3_nxt;
      frame_valid <= frame_valid_nxt;
      sync_err    <= sync_err_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    slot_nxt        = slot;
    sh0_nxt         = sh0;
    sh1_nxt         = sh1;
    sh2_nxt         = sh2;
    ch0_nxt         = ch0_out;
    ch1_nxt         = ch1_out;
    ch2_nxt         = ch2_out;
    ch3_nxt         = ch3_out;
    frame_valid_nxt = 1'b0;
    sync_err_nxt    = 1'b0;

    if (din_valid) begin
      case (state)
        HUNT: begin
          if (frame_sync) begin
            sh0_nxt   = din;
            slot_nxt  = 2'd1;
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // A sync anywhere but slot 0 abandons the partial frame and restarts it.
            sync_err_nxt = (slot != 2'd0);
            sh0_nxt      = din;
            slot_nxt     = 2'd1;
          end else begin
            case (slot)
              2'd0: begin
                sync_err_nxt = 1'b1;
                slot_nxt     = 2'd0;
                state_nxt    = HUNT;
              end
              2'd1: begin
                sh1_nxt  = din;
                slot_nxt = 2'd2;
              end
              2'd2: begin
                sh2_nxt  = din;
                slot_nxt = 2'd3;
              end
              default: begin
                ch0_nxt         = sh0;
                ch1_nxt         = sh1;
                ch2_nxt         = sh2;
                ch3_nxt         = din;
                frame_valid_nxt = 1'b1;
                slot_nxt        = 2'd0;
              end
            endcase
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: doc/tdm_demux_1x4.md
Name: tdm_demux_1x4

Overview:
- Receive end of the team's 4:1 time-division multiplex link.
- Accepts one WIDTH-bit word per valid cycle from a single shared channel, carrying channels 0..3 in rotation, with frame_sync marking the channel-0 word.
- Rebuilds the four parallel channel words and presents them together, one frame at a time.
- Sits directly downstream of the mux/serializer, on the same clock domain.

Parameters:
- WIDTH, 8, bit width of each channel word and of din.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- din  in  WIDTH  multiplexed data word.
- din_valid  in  1  din is valid this cycle; no backpressure.
- frame_sync  in  1  qualified by din_valid; marks din as the channel-0 word.
- ch0_out  out  WIDTH  channel 0 word of the last complete frame.
- ch1_out  out  WIDTH  channel 1 word of the last complete frame.
- ch2_out  out  WIDTH  channel 2 word of the last complete frame.
- ch3_out  out  WIDTH  channel 3 word of the last complete frame.
- frame_valid  out  1  one-cycle pulse; chN_out updated this cycle.
- locked  out  1  high while in state LOCKED.
- sync_err  out  1  one-cycle pulse on framing violation.
- slot  out  2  index of the next expected channel, 0..3.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, reset_n).
- Reset values: state=HUNT, slot=0, chN_out=0, frame_valid=0, locked=0, sync_err=0, shadow regs=0.
- Reset applies immediately on reset_n low and discards any partial frame.
- Storage: three shadow registers hold words for slots 0..2; the slot-3 word goes straight to the output load.
- Cycles with din_valid=0: nothing changes except that frame_valid/sync_err return to 0; frame_sync is ignored.
- State HUNT (locked=0), per accepted word:
  - frame_sync=0: word discarded, slot stays 0.
  - frame_sync=1: word stored as slot 0, slot<=1, state<=LOCKED.
- State LOCKED (locked=1), per accepted word at slot s:
  - s=0, frame_sync=1: store, slot<=1.
  - s=0, frame_sync=0: lost sync. sync_err pulse, word discarded, slot<=0, state<=HUNT.
  - s=1 or 2, frame_sync=0: store in shadow[s], slot<=s+1.
  - s=1..3, frame_sync=1: early sync. sync_err pulse, partial frame discarded (no frame_valid), word stored as slot 0, slot<=1, stay LOCKED.
  - s=3, frame_sync=0: ch0..ch2_out<=shadow[0..2], ch3_out<=din, frame_valid pulse, slot wraps to 0.
- Latency: frame_valid and the new chN_out are visible on the clock edge that accepts the slot-3 word. All four outputs change on the same edge, never partially.
- chN_out hold their values between frames, through errors, and in HUNT.
- sync_err and frame_valid are never asserted in the same cycle. Each is exactly one cycle per event.
- Back-to-back frames with din_valid held high give a frame_valid every 4 cycles. Gaps in din_valid only stretch the frame.

Test Plan:
- Reset, then din_valid=1 for words A0(sync),A1,A2,A3 = 0x11,0x22,0x33,0x44 -> locked=1 after the first word; on the 4th edge ch0..3_out=0x11,0x22,0x33,0x44, frame_valid 1 cycle, slot=0.
- In HUNT, feed 3 words without sync, then a valid frame 0xA0..0xA3 -> unsynced words ignored (outputs stay 0, no sync_err); frame output 0xA0..0xA3.
- Locked, frame 0x01,0x02 then 0x55 with sync, then 0x66,0x77,0x88 -> sync_err on the 0x55 edge, no frame_valid for the partial frame; next frame_valid shows 0x55,0x66,0x77,0x88.
- Locked at slot 0, word 0x99 with frame_sync=0 -> sync_err pulse, locked=0, outputs keep the previous frame, slot=0.
- Valid frame with din_valid=0 gaps of 1-3 cycles between words -> identical outputs; frame_valid only on the slot-3 word, state/slot frozen during gaps.
- reset_n low asynchronously mid-frame (slot=2) -> all outputs 0 immediately; after release, a new frame decodes correctly from HUNT.
